// File: rtl/uart_host_pkg.sv
// rtl/uart_host_pkg.sv - shared widths and TX sequencer state encodings for uart_host_fifo
package uart_host_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_LOAD  = 2'd1,
        T_GUARD = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with wrap-bit pointers, full/empty and occupancy
module uart_sync_fifo #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is still taken when the head leaves on the same edge:
    // the new byte lands in the slot being vacated.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_host_fifo.sv
// rtl/uart_host_fifo.sv - host-side TX/RX byte buffering in front of the UART transceiver
module uart_host_fifo
    import uart_host_pkg::*;
#(
    parameter int TX_AW = 4,
    parameter int RX_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [BYTE_W-1:0] rx_data,
    input  logic              rx_ready,
    output logic [TX_AW:0]    tx_level,
    output logic [RX_AW:0]    rx_level,
    output logic              rx_overrun,
    input  logic              overrun_clr,
    output logic              uart_load,
    output logic [BYTE_W-1:0] uart_d,
    input  logic              uart_txbusy,
    input  logic              uart_bytercvd,
    input  logic [BYTE_W-1:0] uart_q
);

    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;
    logic              tx_pop;
    logic [BYTE_W-1:0] tx_head;
    logic              rx_full;
    logic              rx_empty;
    logic              rx_pop;
    logic              rx_drop;
    logic              load_start;
    tx_state_e         state;
    tx_state_e         state_nxt;

    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && tx_ready;
    assign tx_pop   = load_start;

    uart_sync_fifo #(.AW(TX_AW), .DW(BYTE_W)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .wdata (tx_data),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_ready && rx_valid;
    assign rx_drop  = uart_bytercvd && rx_full && !rx_pop;

    uart_sync_fifo #(.AW(RX_AW), .DW(BYTE_W)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (uart_bytercvd),
        .wdata (uart_q),
        .pop   (rx_pop),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    // T_GUARD skips one txbusy sample because the transceiver raises busy a cycle after load.
    always_comb begin
        state_nxt  = state;
        load_start = 1'b0;
        case (state)
            T_IDLE: begin
                if (!tx_empty && !uart_txbusy) begin
                    load_start = 1'b1;
                    state_nxt  = T_LOAD;
                end
            end
            T_LOAD:  state_nxt = T_GUARD;
            T_GUARD: state_nxt = T_IDLE;
            default: state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= T_IDLE;
            uart_load  <= 1'b0;
            uart_d     <= '0;
            rx_overrun <= 1'b0;
        end else begin
            state     <= state_nxt;
            uart_load <= load_start;
            if (load_start) begin
                uart_d <= tx_head;
            end
            if (rx_drop) begin
                rx_overrun <= 1'b1;
            end else if (overrun_clr) begin
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule
